// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
package rf_wb_arbiter_pkg;

    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

    // Default register-file geometry.
    localparam int RegAddrW = 5;
    localparam int InstW    = 32;
    localparam int Regnum   = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic          found;
    int            idx;

    // Cyclic search from ptr; the winner's successor becomes the next pointer.
    always_comb begin
        gnt      = '0;
        ptr_next = ptr;
        found    = Disable;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = Enable;
                found    = Enable;
                ptr_next = PW'((idx + 1) % N);
            end
        end
    end

    // Pointer only moves when a grant is actually made.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (adv && found)
            ptr <= ptr_next;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and busy-bit scoreboard for the integer register file.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = RegAddrW,
    parameter int DATA_W = InstW,
    parameter int REGNUM = Regnum
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic                     issue_ready,
    input  logic [ADDR_W-1:0]        rs1_raddr,
    input  logic [ADDR_W-1:0]        rs2_raddr,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic                     wen,
    output logic [ADDR_W-1:0]        rd_waddr,
    output logic [DATA_W-1:0]        rd_wdata
);

    logic [NREQ-1:0]   gnt;
    logic              any_gnt;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic [REGNUM-1:0] busy;
    logic [REGNUM-1:0] busy_next;
    logic              issue_set;

    // The output stage never stalls, so the arbiter advances on every grant.
    rr_arbiter #(.N(NREQ)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .adv (Enable),
        .gnt (gnt)
    );

    assign req_ready = gnt;
    assign any_gnt   = |gnt;

    // Select the winning requester's address and data slice.
    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Registered write port; x0 writes are consumed but never enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen      <= Disable;
            rd_waddr <= '0;
            rd_wdata <= '0;
        end else begin
            wen <= any_gnt && (win_addr != '0);
            if (any_gnt) begin
                rd_waddr <= win_addr;
                rd_wdata <= win_data;
            end
        end
    end

    // busy[0] is never set, so x0 always reads as free.
    assign issue_ready = (issue_addr == '0) ? Enable : !busy[issue_addr];
    assign issue_set   = issue_valid && issue_ready && (issue_addr != '0);
    assign rs1_busy    = busy[rs1_raddr];
    assign rs2_busy    = busy[rs2_raddr];

    // Clear on write, then set on issue so a same-register collision keeps the claim.
    always_comb begin
        busy_next = busy;
        if (wen)
            busy_next[rd_waddr] = Disable;
        if (issue_set)
            busy_next[issue_addr] = Enable;
        busy_next[0] = Disable;
    end

    // Scoreboard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_next;
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: per-cycle model compare plus directed checks.
module tb_rf_wb_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 issue_valid;
    logic [AW-1:0]        issue_addr;
    logic                 issue_ready;
    logic [AW-1:0]        rs1_raddr, rs2_raddr;
    logic                 rs1_busy, rs2_busy;
    logic                 wen;
    logic [AW-1:0]        rd_waddr;
    logic [DW-1:0]        rd_wdata;

    int nvec = 0;
    int nerr = 0;

    rf_wb_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .REGNUM(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
        .rs1_raddr(rs1_raddr), .rs2_raddr(rs2_raddr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wen(wen), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_ptr;
    bit [31:0]   m_busy;
    bit          m_wen;
    bit [AW-1:0] m_waddr;
    bit [DW-1:0] m_wdata;
    int          nx_ptr;
    bit [31:0]   nx_busy;
    bit          nx_wen;
    bit [AW-1:0] nx_waddr;
    bit [DW-1:0] nx_wdata;

    // Compare outputs mid-cycle against the model, then work out the model's next state.
    always @(negedge clk) begin
        int g;
        bit [AW-1:0] ga;
        bit exp_ir;
        g = -1;
        for (int k = 0; k < NREQ; k++)
            if (g < 0 && req_valid[(m_ptr + k) % NREQ] === 1'b1) g = (m_ptr + k) % NREQ;
        exp_ir = (issue_addr == 0) || !m_busy[issue_addr];
        chk("m_req_ready", {29'd0, req_ready}, (g < 0) ? 32'd0 : (32'd1 << g));
        chk("m_issue_ready", {31'd0, issue_ready}, {31'd0, exp_ir});
        chk("m_rs1_busy", {31'd0, rs1_busy}, {31'd0, m_busy[rs1_raddr]});
        chk("m_rs2_busy", {31'd0, rs2_busy}, {31'd0, m_busy[rs2_raddr]});
        chk("m_wen", {31'd0, wen}, {31'd0, m_wen});
        chk("m_rd_waddr", {27'd0, rd_waddr}, {27'd0, m_waddr});
        chk("m_rd_wdata", rd_wdata, m_wdata);
        ga       = (g < 0) ? '0 : req_addr[g*AW +: AW];
        nx_ptr   = (g < 0) ? m_ptr : (g + 1) % NREQ;
        nx_wen   = (g >= 0) && (ga != 0);
        nx_waddr = (g < 0) ? m_waddr : ga;
        nx_wdata = (g < 0) ? m_wdata : req_data[g*DW +: DW];
        nx_busy  = m_busy;
        if (m_wen) nx_busy[m_waddr] = 1'b0;
        if (issue_valid && exp_ir && issue_addr != 0) nx_busy[issue_addr] = 1'b1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr = 0; m_busy = '0; m_wen = 0; m_waddr = '0; m_wdata = '0;
        end else begin
            m_ptr = nx_ptr; m_busy = nx_busy; m_wen = nx_wen;
            m_waddr = nx_waddr; m_wdata = nx_wdata;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_addr = '0; req_data = '0;
        issue_valid = 1'b0; issue_addr = '0; rs1_raddr = '0; rs2_raddr = '0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_req_ready", {29'd0, req_ready}, 32'd0);
        chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
        chk("rst_wen", {31'd0, wen}, 32'd0);
        chk("rst_rd_wdata", rd_wdata, 32'd0);

        // Fairness: all three held valid for six cycles.
        set_req(0, 5'd1, 32'h100); set_req(1, 5'd2, 32'h200); set_req(2, 5'd3, 32'h300);
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("fair_gnt", {29'd0, req_ready}, 32'd1 << (c % 3));
            step();
        end
        req_valid = '0;

        // Single write from requester 1.
        set_req(1, 5'd7, 32'hDEADBEEF);
        req_valid = 3'b010;
        #1 chk("single_gnt", {29'd0, req_ready}, 32'h2);
        step();
        req_valid = '0;
        chk("single_wen", {31'd0, wen}, 32'd1);
        chk("single_waddr", {27'd0, rd_waddr}, 32'd7);
        chk("single_wdata", rd_wdata, 32'hDEADBEEF);

        // Scoreboard: claim x3, reject duplicate, clear via write, re-claim.
        issue_valid = 1'b1; issue_addr = 5'd3; rs1_raddr = 5'd3;
        #1 chk("iss3_ready", {31'd0, issue_ready}, 32'd1);
        step();
        issue_valid = 1'b0;
        chk("iss3_busy", {31'd0, rs1_busy}, 32'd1);
        issue_valid = 1'b1;
        #1 chk("iss3_dup", {31'd0, issue_ready}, 32'd0);
        step();
        issue_valid = 1'b0;
        set_req(0, 5'd3, 32'h33); req_valid = 3'b001;
        #1 chk("wr3_gnt", {29'd0, req_ready}, 32'h1);
        step();
        req_valid = '0;
        chk("wr3_busy_n1", {31'd0, rs1_busy}, 32'd1);
        step();
        chk("wr3_busy_n2", {31'd0, rs1_busy}, 32'd0);
        issue_valid = 1'b1;
        #1 chk("iss3_again", {31'd0, issue_ready}, 32'd1);
        step();
        issue_valid = 1'b0;

        // x0: consumed without write; claim always accepted, never busy.
        set_req(2, 5'd0, 32'h1234); req_valid = 3'b100;
        #1 chk("x0_gnt", {29'd0, req_ready}, 32'h4);
        step();
        req_valid = '0;
        chk("x0_wen", {31'd0, wen}, 32'd0);
        issue_valid = 1'b1; issue_addr = 5'd0;
        #1 chk("x0_issue", {31'd0, issue_ready}, 32'd1);
        step();
        issue_valid = 1'b0; rs2_raddr = 5'd0;
        #1 chk("x0_rs2", {31'd0, rs2_busy}, 32'd0);

        // Unclaimed write to x9 collides with a fresh claim of x9: the claim survives.
        set_req(1, 5'd9, 32'h99); req_valid = 3'b010;
        step();
        req_valid = '0;
        issue_valid = 1'b1; issue_addr = 5'd9;
        #1 chk("x9_issue", {31'd0, issue_ready}, 32'd1);
        step();
        issue_valid = 1'b0; rs1_raddr = 5'd9;
        #1 chk("x9_setwins", {31'd0, rs1_busy}, 32'd1);

        // Pseudo-random traffic checked by the model only.
        for (int c = 0; c < 40; c++) begin
            req_valid = 3'($urandom_range(0, 7));
            for (int i = 0; i < NREQ; i++) set_req(i, 5'($urandom_range(0, 31)), $urandom);
            issue_valid = 1'($urandom_range(0, 1));
            issue_addr  = 5'($urandom_range(0, 31));
            rs1_raddr   = 5'($urandom_range(0, 31));
            rs2_raddr   = 5'($urandom_range(0, 31));
            step();
        end
        req_valid = '0; issue_valid = 1'b0;

        // Reset mid-operation with busy[5]=1 and a write in flight.
        rst = 1'b1; step(); rst = 1'b0;
        issue_valid = 1'b1; issue_addr = 5'd5;
        step();
        issue_valid = 1'b0;
        set_req(0, 5'd6, 32'hAA); req_valid = 3'b001;
        step();
        req_valid = '0; rs1_raddr = 5'd5;
        #1;
        chk("pre_rst_wen", {31'd0, wen}, 32'd1);
        chk("pre_rst_busy5", {31'd0, rs1_busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_wen", {31'd0, wen}, 32'd0);
        chk("mid_rst_waddr", {27'd0, rd_waddr}, 32'd0);
        chk("mid_rst_wdata", rd_wdata, 32'd0);
        chk("mid_rst_issue5", {31'd0, issue_ready}, 32'd1);
        chk("mid_rst_busy5", {31'd0, rs1_busy}, 32'd0);
        step();
        rst = 1'b0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
